// File: rtl/riscv_pkg.sv
// Shared RV32I constants: ALU select codes (also used by the ALU), opcodes, funct7 values.
package riscv_pkg;

    localparam int WORD_SIZE_DEFAULT  = 32;
    localparam int REG_ADDR_W_DEFAULT = 5;

    typedef enum logic [3:0] {
        ALU_NOP  = 4'h0,
        ALU_ADD  = 4'h1,
        ALU_SUB  = 4'h2,
        ALU_XOR  = 4'h3,
        ALU_OR   = 4'h4,
        ALU_AND  = 4'h5,
        ALU_SLL  = 4'h6,
        ALU_SRL  = 4'h7,
        ALU_SRA  = 4'h8,
        ALU_SLT  = 4'h9,
        ALU_SLTU = 4'hA
    } alu_sel_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;

    localparam logic [6:0] F7_ZERO = 7'h00;
    localparam logic [6:0] F7_ALT  = 7'h20;

endpackage

// File: rtl/decode_stage_imm_gen.sv
// Combinational I/S/U immediate generator; the format is chosen from the opcode field.
module imm_gen
    import riscv_pkg::*;
#(
    parameter int WORD_SIZE = WORD_SIZE_DEFAULT
) (
    input  logic [31:0]          instr_i,
    output logic [WORD_SIZE-1:0] imm_o
);

    logic signed [31:0] imm32;

    always_comb begin
        imm32 = '0;
        case (instr_i[6:0])
            OPC_OP_IMM,
            OPC_LOAD:   imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
            OPC_STORE:  imm32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
            OPC_LUI,
            OPC_AUIPC:  imm32 = {instr_i[31:12], 12'b0};
            default:    imm32 = '0;
        endcase
    end

    assign imm_o = WORD_SIZE'(imm32);

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: decodes one instruction per transfer, reads the regfile combinationally
// and registers ALU operands plus writeback control behind a valid/ready handshake.
module decode_stage
    import riscv_pkg::*;
#(
    parameter int WORD_SIZE  = WORD_SIZE_DEFAULT,
    parameter int REG_ADDR_W = REG_ADDR_W_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WORD_SIZE-1:0]  in_instr,
    input  logic [WORD_SIZE-1:0]  in_pc,
    output logic [REG_ADDR_W-1:0] rs1_addr,
    output logic [REG_ADDR_W-1:0] rs2_addr,
    input  logic [WORD_SIZE-1:0]  rs1_data,
    input  logic [WORD_SIZE-1:0]  rs2_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [3:0]            alu_sel,
    output logic [WORD_SIZE-1:0]  arg_a,
    output logic [WORD_SIZE-1:0]  arg_b,
    output logic [REG_ADDR_W-1:0] rd_addr,
    output logic                  rd_we,
    output logic                  is_load,
    output logic                  is_store,
    output logic [WORD_SIZE-1:0]  store_data,
    output logic                  illegal
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] rd_field;
    logic [WORD_SIZE-1:0] imm;
    logic [WORD_SIZE-1:0] shamt;
    logic accept;

    alu_sel_e              alu_sel_d,    alu_sel_q;
    logic [WORD_SIZE-1:0]  arg_a_d,      arg_a_q;
    logic [WORD_SIZE-1:0]  arg_b_d,      arg_b_q;
    logic [REG_ADDR_W-1:0] rd_addr_d,    rd_addr_q;
    logic                  rd_we_d,      rd_we_q;
    logic                  is_load_d,    is_load_q;
    logic                  is_store_d,   is_store_q;
    logic [WORD_SIZE-1:0]  store_data_d, store_data_q;
    logic                  illegal_d,    illegal_q;
    logic                  out_valid_q;

    assign opcode   = in_instr[6:0];
    assign funct3   = in_instr[14:12];
    assign funct7   = in_instr[31:25];
    assign rd_field = in_instr[11:7];
    assign shamt    = {{(WORD_SIZE-5){1'b0}}, in_instr[24:20]};

    assign rs1_addr = REG_ADDR_W'(in_instr[19:15]);
    assign rs2_addr = REG_ADDR_W'(in_instr[24:20]);

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready && !flush;

    imm_gen #(
        .WORD_SIZE (WORD_SIZE)
    ) u_imm_gen (
        .instr_i (in_instr[31:0]),
        .imm_o   (imm)
    );

    always_comb begin
        alu_sel_d    = ALU_NOP;
        arg_a_d      = '0;
        arg_b_d      = '0;
        rd_addr_d    = REG_ADDR_W'(rd_field);
        rd_we_d      = 1'b0;
        is_load_d    = 1'b0;
        is_store_d   = 1'b0;
        store_data_d = '0;
        illegal_d    = 1'b0;

        case (opcode)
            OPC_OP: begin
                arg_a_d = rs1_data;
                arg_b_d = rs2_data;
                if (funct7 == F7_ZERO) begin
                    case (funct3)
                        3'b000:  alu_sel_d = ALU_ADD;
                        3'b001:  alu_sel_d = ALU_SLL;
                        3'b010:  alu_sel_d = ALU_SLT;
                        3'b011:  alu_sel_d = ALU_SLTU;
                        3'b100:  alu_sel_d = ALU_XOR;
                        3'b101:  alu_sel_d = ALU_SRL;
                        3'b110:  alu_sel_d = ALU_OR;
                        default: alu_sel_d = ALU_AND;
                    endcase
                end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
                    alu_sel_d = ALU_SUB;
                end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
                    alu_sel_d = ALU_SRA;
                end else begin
                    illegal_d = 1'b1;
                end
            end
            OPC_OP_IMM: begin
                arg_a_d = rs1_data;
                arg_b_d = imm;
                case (funct3)
                    3'b000:  alu_sel_d = ALU_ADD;
                    3'b010:  alu_sel_d = ALU_SLT;
                    3'b011:  alu_sel_d = ALU_SLTU;
                    3'b100:  alu_sel_d = ALU_XOR;
                    3'b110:  alu_sel_d = ALU_OR;
                    3'b111:  alu_sel_d = ALU_AND;
                    3'b001: begin
                        arg_b_d = shamt;
                        if (funct7 == F7_ZERO) alu_sel_d = ALU_SLL;
                        else                   illegal_d = 1'b1;
                    end
                    default: begin
                        arg_b_d = shamt;
                        if (funct7 == F7_ZERO)     alu_sel_d = ALU_SRL;
                        else if (funct7 == F7_ALT) alu_sel_d = ALU_SRA;
                        else                       illegal_d = 1'b1;
                    end
                endcase
            end
            OPC_LUI: begin
                alu_sel_d = ALU_ADD;
                arg_b_d   = imm;
            end
            OPC_AUIPC: begin
                alu_sel_d = ALU_ADD;
                arg_a_d   = in_pc;
                arg_b_d   = imm;
            end
            OPC_LOAD: begin
                alu_sel_d = ALU_ADD;
                arg_a_d   = rs1_data;
                arg_b_d   = imm;
                is_load_d = 1'b1;
            end
            OPC_STORE: begin
                alu_sel_d    = ALU_ADD;
                arg_a_d      = rs1_data;
                arg_b_d      = imm;
                is_store_d   = 1'b1;
                store_data_d = rs2_data;
                rd_addr_d    = '0;
            end
            default: illegal_d = 1'b1;
        endcase

        // Illegal encodings still travel down the pipe, but with a neutral payload.
        if (illegal_d) begin
            alu_sel_d    = ALU_NOP;
            arg_a_d      = '0;
            arg_b_d      = '0;
            rd_addr_d    = '0;
            is_load_d    = 1'b0;
            is_store_d   = 1'b0;
            store_data_d = '0;
        end

        rd_we_d = !illegal_d && !is_store_d && (rd_field != 5'd0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            alu_sel_q    <= ALU_NOP;
            arg_a_q      <= '0;
            arg_b_q      <= '0;
            rd_addr_q    <= '0;
            rd_we_q      <= 1'b0;
            is_load_q    <= 1'b0;
            is_store_q   <= 1'b0;
            store_data_q <= '0;
            illegal_q    <= 1'b0;
        end else if (flush) begin
            out_valid_q <= 1'b0;
        end else if (accept) begin
            out_valid_q  <= 1'b1;
            alu_sel_q    <= alu_sel_d;
            arg_a_q      <= arg_a_d;
            arg_b_q      <= arg_b_d;
            rd_addr_q    <= rd_addr_d;
            rd_we_q      <= rd_we_d;
            is_load_q    <= is_load_d;
            is_store_q   <= is_store_d;
            store_data_q <= store_data_d;
            illegal_q    <= illegal_d;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid  = out_valid_q;
    assign alu_sel    = alu_sel_q;
    assign arg_a      = arg_a_q;
    assign arg_b      = arg_b_q;
    assign rd_addr    = rd_addr_q;
    assign rd_we      = rd_we_q;
    assign is_load    = is_load_q;
    assign is_store   = is_store_q;
    assign store_data = store_data_q;
    assign illegal    = illegal_q;

endmodule

// File: tb/tb_decode_stage.sv
// Directed, table-driven bench for decode_stage plus handshake, flush and reset sequences.
module tb_decode_stage;

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] rs1d;
        logic [31:0] rs2d;
        logic [3:0]  alu;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic        we;
        logic        ld;
        logic        st;
        logic [31:0] sd;
        logic        ill;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  alu_sel;
    logic [31:0] arg_a;
    logic [31:0] arg_b;
    logic [4:0]  rd_addr;
    logic        rd_we;
    logic        is_load;
    logic        is_store;
    logic [31:0] store_data;
    logic        illegal;

    int   testsRun = 0;
    int   testsFailed = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    decode_stage dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_instr   (in_instr),
        .in_pc      (in_pc),
        .rs1_addr   (rs1_addr),
        .rs2_addr   (rs2_addr),
        .rs1_data   (rs1_data),
        .rs2_data   (rs2_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .alu_sel    (alu_sel),
        .arg_a      (arg_a),
        .arg_b      (arg_b),
        .rd_addr    (rd_addr),
        .rd_we      (rd_we),
        .is_load    (is_load),
        .is_store   (is_store),
        .store_data (store_data),
        .illegal    (illegal)
    );

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic addVec(input string name, input logic [31:0] instr, input logic [31:0] pc,
                          input logic [31:0] rs1d, input logic [31:0] rs2d, input logic [3:0] alu,
                          input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                          input logic we, input logic ld, input logic st, input logic [31:0] sd,
                          input logic ill);
        vec_t v;
        v.name = name; v.instr = instr; v.pc = pc; v.rs1d = rs1d; v.rs2d = rs2d;
        v.alu = alu; v.a = a; v.b = b; v.rd = rd; v.we = we; v.ld = ld; v.st = st;
        v.sd = sd; v.ill = ill;
        vecs.push_back(v);
    endtask

    task automatic driveInputs(input vec_t v);
        in_instr = v.instr;
        in_pc    = v.pc;
        rs1_data = v.rs1d;
        rs2_data = v.rs2d;
        in_valid = 1'b1;
    endtask

    // Offer one instruction at a negedge, check the combinational register addresses, then let it be taken.
    task automatic applyStimulus(input vec_t v);
        logic [31:0] ins;
        @(negedge clk);
        driveInputs(v);
        ins = v.instr;
        #1;
        checkVal({v.name, ".rs1_addr"}, {27'd0, rs1_addr}, {27'd0, ins[19:15]});
        checkVal({v.name, ".rs2_addr"}, {27'd0, rs2_addr}, {27'd0, ins[24:20]});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic checkOutput(input vec_t v);
        checkVal({v.name, ".out_valid"}, {31'd0, out_valid}, 32'd1);
        checkVal({v.name, ".alu_sel"},   {28'd0, alu_sel},   {28'd0, v.alu});
        checkVal({v.name, ".arg_a"},     arg_a,              v.a);
        checkVal({v.name, ".arg_b"},     arg_b,              v.b);
        checkVal({v.name, ".rd_addr"},   {27'd0, rd_addr},   {27'd0, v.rd});
        checkVal({v.name, ".rd_we"},     {31'd0, rd_we},     {31'd0, v.we});
        checkVal({v.name, ".is_load"},   {31'd0, is_load},   {31'd0, v.ld});
        checkVal({v.name, ".is_store"},  {31'd0, is_store},  {31'd0, v.st});
        checkVal({v.name, ".illegal"},   {31'd0, illegal},   {31'd0, v.ill});
        if (v.st) checkVal({v.name, ".store_data"}, store_data, v.sd);
    endtask

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_instr  = 32'h0000_0013;
        in_pc     = '0;
        rs1_data  = '0;
        rs2_data  = '0;

        //     name      instr          pc          rs1         rs2          alu    a            b            rd  we ld st sd           ill
        addVec("addi",   32'hFFF10093, 32'h0,     32'd5,      32'd0,       4'h1, 32'd5,       32'hFFFFFFFF, 5'd1, 1, 0, 0, 32'h0,       0);
        addVec("sub",    32'h402081B3, 32'h0,     32'd10,     32'd3,       4'h2, 32'd10,      32'd3,        5'd3, 1, 0, 0, 32'h0,       0);
        addVec("srai",   32'h4033D313, 32'h0,     32'h80000000, 32'd0,     4'h8, 32'h80000000, 32'd3,       5'd6, 1, 0, 0, 32'h0,       0);
        addVec("lui",    32'h123452B7, 32'h0,     32'h55,     32'h66,      4'h1, 32'h0,       32'h12345000, 5'd5, 1, 0, 0, 32'h0,       0);
        addVec("auipc",  32'h12345297, 32'h100,   32'h55,     32'h66,      4'h1, 32'h100,     32'h12345000, 5'd5, 1, 0, 0, 32'h0,       0);
        addVec("lw",     32'hFFC12203, 32'h0,     32'h1000,   32'h0,       4'h1, 32'h1000,    32'hFFFFFFFC, 5'd4, 1, 1, 0, 32'h0,       0);
        addVec("sw",     32'h00512423, 32'h0,     32'h2000,   32'hDEADBEEF, 4'h1, 32'h2000,   32'd8,        5'd0, 0, 0, 1, 32'hDEADBEEF, 0);
        addVec("swneg",  32'hFE512C23, 32'h0,     32'h3000,   32'h12345678, 4'h1, 32'h3000,   32'hFFFFFFF8, 5'd0, 0, 0, 1, 32'h12345678, 0);
        addVec("opc7f",  32'h0000007F, 32'h0,     32'h11,     32'h22,      4'h0, 32'h0,       32'h0,        5'd0, 0, 0, 0, 32'h0,       1);
        addVec("addf7",  32'h023100B3, 32'h0,     32'h11,     32'h22,      4'h0, 32'h0,       32'h0,        5'd0, 0, 0, 0, 32'h0,       1);
        addVec("slli20", 32'h40311093, 32'h0,     32'h11,     32'h22,      4'h0, 32'h0,       32'h0,        5'd0, 0, 0, 0, 32'h0,       1);
        addVec("addix0", 32'h00100013, 32'h0,     32'd7,      32'd0,       4'h1, 32'd7,       32'd1,        5'd0, 0, 0, 0, 32'h0,       0);
        addVec("xor",    32'h003140B3, 32'h0,     32'hF0,     32'h0F,      4'h3, 32'hF0,      32'h0F,       5'd1, 1, 0, 0, 32'h0,       0);
        addVec("sra",    32'h403150B3, 32'h0,     32'hF0,     32'h04,      4'h8, 32'hF0,      32'h04,       5'd1, 1, 0, 0, 32'h0,       0);
        addVec("sltiu",  32'h00513093, 32'h0,     32'h9,      32'h0,       4'hA, 32'h9,       32'd5,        5'd1, 1, 0, 0, 32'h0,       0);
        addVec("srli",   32'h01F15093, 32'h0,     32'h9,      32'h0,       4'h7, 32'h9,       32'd31,       5'd1, 1, 0, 0, 32'h0,       0);

        repeat (2) @(posedge clk);
        #1;
        checkVal("reset.out_valid", {31'd0, out_valid}, 32'd0);
        checkVal("reset.alu_sel",   {28'd0, alu_sel},   32'd0);
        checkVal("reset.arg_a",     arg_a,              32'd0);
        checkVal("reset.rd_we",     {31'd0, rd_we},     32'd0);
        checkVal("reset.in_ready",  {31'd0, in_ready},  32'd1);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;

        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
            checkOutput(vecs[i]);
        end
        @(posedge clk);
        #1;
        checkVal("drain.out_valid", {31'd0, out_valid}, 32'd0);

        // Backpressure: addi held for three stalled cycles while lui waits at the input.
        out_ready = 1'b0;
        applyStimulus(vecs[0]);
        checkOutput(vecs[0]);
        @(negedge clk);
        driveInputs(vecs[3]);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            checkVal("stall.in_ready",  {31'd0, in_ready},  32'd0);
            checkVal("stall.out_valid", {31'd0, out_valid}, 32'd1);
            checkVal("stall.arg_a",     arg_a,              vecs[0].a);
            checkVal("stall.arg_b",     arg_b,              vecs[0].b);
            checkVal("stall.rd_addr",   {27'd0, rd_addr},   {27'd0, vecs[0].rd});
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checkOutput(vecs[3]);
        @(posedge clk);
        #1;
        checkVal("stall.nodup", {31'd0, out_valid}, 32'd0);

        // Flush while a payload is held and a new instruction is offered.
        out_ready = 1'b0;
        applyStimulus(vecs[1]);
        checkOutput(vecs[1]);
        @(negedge clk);
        driveInputs(vecs[3]);
        flush     = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flush    = 1'b0;
        checkVal("flush.out_valid", {31'd0, out_valid}, 32'd0);
        @(posedge clk);
        #1;
        checkVal("flush.dropped", {31'd0, out_valid}, 32'd0);

        // Asynchronous reset in the middle of a stall, then normal decode afterwards.
        out_ready = 1'b0;
        applyStimulus(vecs[0]);
        checkOutput(vecs[0]);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkVal("arst.out_valid", {31'd0, out_valid}, 32'd0);
        checkVal("arst.alu_sel",   {28'd0, alu_sel},   32'd0);
        checkVal("arst.arg_b",     arg_b,              32'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        applyStimulus(vecs[4]);
        checkOutput(vecs[4]);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- ID pipeline stage that produces the ALU operand and select interface: arg_a, arg_b and a 4-bit alu_sel.
- Decodes one RV32I instruction per transfer and reads the register file combinationally.
- Registers the operands, ALU select and writeback control behind a valid/ready handshake for the EX stage.
- Covers OP, OP-IMM, LUI, AUIPC, LOAD and STORE. Every other opcode is flagged illegal.

Parameters:
WORD_SIZE, 32, datapath width (operands, pc, instr)
REG_ADDR_W, 5, register index width

Ports:
clk  input  1  single clock
rst_n  input  1  asynchronous active-low reset
flush  input  1  discard held and incoming instruction
in_valid  input  1  IF offers instruction
in_ready  output  1  stage can accept
in_instr  input  WORD_SIZE  instruction word
in_pc  input  WORD_SIZE  its pc
rs1_addr  output  REG_ADDR_W  in_instr[19:15], combinational
rs2_addr  output  REG_ADDR_W  in_instr[24:20], combinational
rs1_data  input  WORD_SIZE  regfile read, same cycle
rs2_data  input  WORD_SIZE  regfile read, same cycle
out_valid  output  1  EX payload valid
out_ready  input  1  EX accepts
alu_sel  output  4  ALU op code
arg_a  output  WORD_SIZE  ALU operand A
arg_b  output  WORD_SIZE  ALU operand B
rd_addr  output  REG_ADDR_W  destination
rd_we  output  1  writeback enable
is_load  output  1  LOAD; ALU result is the address
is_store  output  1  STORE; ALU result is the address
store_data  output  WORD_SIZE  rs2_data captured for STORE
illegal  output  1  unsupported/malformed encoding

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: every registered output is 0, including out_valid=0 and alu_sel=0. Code 0 is the ALU's default, which yields 0.
- ALU codes: ADD=1, SUB=2, XOR=3, OR=4, AND=5, SLL=6, SRL=7, SRA=8, SLT=9, SLTU=A.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational; no skid buffer).
  - Accept = in_valid && in_ready && !flush. On accept, the payload is registered and out_valid=1 on the next edge, so latency is 1 cycle.
  - out_valid && out_ready with no accept drives out_valid to 0.
  - When out_valid && !out_ready, all outputs hold stable.
- Flush: has priority. The next edge sets out_valid=0 and drops any concurrent input. Payload registers may keep stale values but must not be consumed.
- Decode (imm = standard I/S/U sign/shift extension):
  - OP (0110011):
    - funct7=0x00 selects by funct3: ADD, SLL, SLT, SLTU, XOR, SRL, OR, AND.
    - funct7=0x20 is valid only with funct3 000 (SUB) or 101 (SRA).
    - Any other funct7 is illegal.
    - a=rs1_data, b=rs2_data.
  - OP-IMM (0010011):
    - funct3 gives ADD, SLT, SLTU, XOR, OR, AND with b=I-imm.
    - SLLI requires funct7=0x00. SRLI/SRAI require funct7 0x00/0x20. Otherwise illegal.
    - For shifts, b = zero-extended shamt.
  - LUI: a=0, b=U-imm, ADD.
  - AUIPC: a=in_pc, b=U-imm, ADD.
  - LOAD: a=rs1, b=I-imm, ADD, is_load=1.
  - STORE: a=rs1, b=S-imm, ADD, is_store=1, rd_we=0, store_data=rs2_data.
- rd_we = 1 for OP/OP-IMM/LUI/AUIPC/LOAD when rd != 0.
- Illegal instruction: still transferred with illegal=1, alu_sel=0, rd_we=0, is_load=0, is_store=0, arg_a=arg_b=0.
- Hazards and forwarding are not handled here; they belong to a separate unit.

Decomposition:
- Shared package riscv_pkg holds:
  - ALU code constants, shared with the ALU so the two cannot diverge.
  - Opcode constants.
  - funct7 constants 0x00/0x20.
  - WORD_SIZE default.
- One sub-module: imm_gen, a combinational I/S/U immediate generator selected by opcode.

Test Plan:
- addi x1,x2,-1 (0xFFF10093), rs1_data=5, out_ready=1 -> next cycle out_valid=1, alu_sel=1, arg_a=5, arg_b=0xFFFFFFFF, rd_addr=1, rd_we=1; rs1_addr=2 combinationally.
- sub x3,x1,x2 (0x402081B3), rs1_data=10, rs2_data=3 -> alu_sel=2, arg_a=10, arg_b=3, rd_addr=3. srai x6,x7,3 (0x4033D313) -> alu_sel=8, arg_b=3.
- lui x5,0x12345 (0x123452B7) -> arg_a=0, arg_b=0x12345000, alu_sel=1. auipc at pc=0x100 with same imm -> arg_a=0x100.
- Backpressure: two back-to-back instrs, out_ready=0 for 3 cycles -> in_ready=0, outputs frozen on first; second appears one cycle after out_ready=1; no loss or duplicate.
- Flush asserted with out_valid=1 and in_valid=1 -> next cycle out_valid=0, dropped instr never appears. Opcode 0x7F or add with funct7=0x01 -> illegal=1, rd_we=0, alu_sel=0.
- rst_n low mid-stall with out_valid=1 -> out_valid=0 and alu_sel=0 immediately without a clock edge; after release, first accepted instr decodes normally.
